// File: rtl/decoder_controller_if.sv
// ---------------------------------------------------------------------------
// decoder_controller_if
// Handshake bundle between the decoder top level and its control unit.
//
//   start       top -> ctrl   request a decode (pulse or level)
//   finish      ctrl -> top   one-cycle pulse when all rounds are done
//   X_start     ctrl -> unit  one-cycle start for inverse step unit X
//   X_finish    unit -> ctrl  unit X done (level or pulse)
//   iteration   ctrl -> top   current round index, IW bits
//
// Modports:
//   slave  - the controller side
//   master - the decoder top / datapath side
// ---------------------------------------------------------------------------
interface decoder_controller_if #(
  parameter int IW = 6
);
  logic          start;
  logic          finish;
  logic          RC_start;
  logic          RE_start;
  logic          PE_start;
  logic          RO_start;
  logic          CP_start;
  logic          RC_finish;
  logic          RE_finish;
  logic          PE_finish;
  logic          RO_finish;
  logic          CP_finish;
  logic [IW-1:0] iteration;

  modport slave (
    input  start,
    input  RC_finish, RE_finish, PE_finish, RO_finish, CP_finish,
    output finish,
    output RC_start, RE_start, PE_start, RO_start, CP_start,
    output iteration
  );

  modport master (
    output start,
    output RC_finish, RE_finish, PE_finish, RO_finish, CP_finish,
    input  finish,
    input  RC_start, RE_start, PE_start, RO_start, CP_start,
    input  iteration
  );
endinterface

// File: rtl/decoder_controller.sv
// ---------------------------------------------------------------------------
// decoder_controller
// Control unit for the decoder: runs the inverse permutation by sequencing
// five inverse step units per round in the order RC^-1, RE^-1 (chi),
// PE^-1 (pi), RO^-1 (rho), CP^-1 (theta). Rounds count down from ROUNDS-1
// to 0; the round index is shared with the datapath on bus.iteration.
//
// Ports:
//   clk   in   rising-edge clock
//   rst   in   asynchronous, active-high reset
//   bus   slave modport of decoder_controller_if (start/finish handshake,
//         per-unit start/finish pairs, iteration index)
//
// Parameters:
//   ROUNDS  number of rounds (iteration runs ROUNDS-1 .. 0)
//   IW      iteration width, 2**IW >= ROUNDS
// ---------------------------------------------------------------------------
module decoder_controller #(
  parameter int ROUNDS = 24,
  parameter int IW     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE,
    ARM,
    RC_S,
    RC_W,
    RE_S,
    RE_W,
    PE_S,
    PE_W,
    RO_S,
    RO_W,
    CP_S,
    CP_W,
    DONE
  } state_t;

  localparam logic [IW-1:0] LAST_ROUND = IW'(ROUNDS - 1);

  state_t        r_state;
  state_t        w_nextState;
  logic [IW-1:0] r_iteration;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Loaded when ARM sees start released; stepped down only once the last
  // step of a round finishes, and never below zero so it rests at 0 after
  // the final round.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iteration <= '0;
    end else if (r_state == ARM && !bus.start) begin
      r_iteration <= LAST_ROUND;
    end else if (r_state == CP_W && bus.CP_finish && r_iteration != '0) begin
      r_iteration <= r_iteration - IW'(1);
    end
  end

  // Each *_S state lasts exactly one cycle; the matching *_W state only
  // listens to its own unit's finish, so finishes arriving during *_S or
  // from other units are ignored. ARM waits for start to drop so a held
  // start cannot immediately re-trigger a run.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.start) w_nextState = ARM;
      ARM:  if (!bus.start) w_nextState = RC_S;
      RC_S: w_nextState = RC_W;
      RC_W: if (bus.RC_finish) w_nextState = RE_S;
      RE_S: w_nextState = RE_W;
      RE_W: if (bus.RE_finish) w_nextState = PE_S;
      PE_S: w_nextState = PE_W;
      PE_W: if (bus.PE_finish) w_nextState = RO_S;
      RO_S: w_nextState = RO_W;
      RO_W: if (bus.RO_finish) w_nextState = CP_S;
      CP_S: w_nextState = CP_W;
      CP_W: begin
        if (bus.CP_finish) begin
          w_nextState = (r_iteration == '0) ? DONE : RC_S;
        end
      end
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Moore outputs: pure decode of the registered state.
  assign bus.RC_start  = (r_state == RC_S);
  assign bus.RE_start  = (r_state == RE_S);
  assign bus.PE_start  = (r_state == PE_S);
  assign bus.RO_start  = (r_state == RO_S);
  assign bus.CP_start  = (r_state == CP_S);
  assign bus.finish    = (r_state == DONE);
  assign bus.iteration = r_iteration;

endmodule
